// File: rtl/fft_spectrum_bars.sv
// Purpose : reduce the FFT Xk stream to NUM_BARS bar heights (approx |X| of the lower half, max per group) in a double-buffered table.
// Latency : last bin accepted in cycle T -> table published, frame_done high in T+4; rd_data is 1 cycle after rd_addr.
// Backpr. : none; one bin is consumed on every in_valid cycle, the read port can be used at any time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_sop      bin strobe, first-bin marker (qualified by in_valid)
//   xk_re, xk_im          signed FFT output bin
//   rd_addr, rd_data      display table read port (registered)
//   frame_done            one-cycle pulse when a new table is published
//   busy                  high while a frame is being accumulated
//   sync_err              one-cycle pulse when in_sop arrives in the middle of a frame
// Build option: SPECTRUM_PEAK_HOLD_EN -- publish max(new bar, old display - 1) instead of the new bar.
module fft_spectrum_bars #(
  parameter int FFT_POINTS = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BARS   = 32,
  parameter int BAR_WIDTH  = 8,
  parameter int MAG_SHIFT  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_sop,
  input  logic signed [DATA_WIDTH-1:0]  xk_re,
  input  logic signed [DATA_WIDTH-1:0]  xk_im,
  input  logic [$clog2(NUM_BARS)-1:0]   rd_addr,
  output logic [BAR_WIDTH-1:0]          rd_data,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          sync_err
);

  localparam int CNT_W  = $clog2(FFT_POINTS);
  localparam int BAR_AW = $clog2(NUM_BARS);
  localparam int GRP    = (FFT_POINTS / 2) / NUM_BARS;
  localparam int GRP_W  = $clog2(GRP);
  localparam int MAG_W  = DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0]     GRP_MASK = CNT_W'(GRP - 1);
  localparam logic [CNT_W-1:0]     LAST_BIN = CNT_W'(FFT_POINTS - 1);
  localparam logic [BAR_WIDTH-1:0] H_MAX    = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             next_open, next_open_nxt;  // next frame already started while draining
  logic             frame_open, accept, sop_mid, last_acc, swap, tag_bank;
  logic [CNT_W-1:0] bin_idx;
  logic             disp_sel;                  // bank currently shown; the other one is the work bank
  logic             pub_pend;                  // last bin of the frame has just been written

  // Pipeline registers
  logic                  s1_vld, s1_last, s1_bank;
  logic [CNT_W-1:0]      s1_bin;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  logic                  s2_vld, s2_last, s2_bank;
  logic [CNT_W-1:0]      s2_bin;
  logic [MAG_W-1:0]      s2_mag;

  logic [BAR_WIDTH-1:0]  bank [2][NUM_BARS];
  logic [BAR_WIDTH-1:0]  pub_val [NUM_BARS];

  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] u;
    u = x;
    // Two's complement negate; the most negative value lands on 2^(DATA_WIDTH-1) unsigned.
    return u[DATA_WIDTH-1] ? (~u + DATA_WIDTH'(1)) : u;
  endfunction

`ifdef SPECTRUM_PEAK_HOLD_EN
  function automatic logic [BAR_WIDTH-1:0] hold_val(input logic [BAR_WIDTH-1:0] nw,
                                                    input logic [BAR_WIDTH-1:0] old);
    logic [BAR_WIDTH-1:0] dec;
    dec = (old == '0) ? '0 : old - BAR_WIDTH'(1);
    return (nw > dec) ? nw : dec;
  endfunction
`endif

  // ---------------------------------------------------------------- control
  always_comb begin
    frame_open    = (state == ACCUM) || ((state == DRAIN) && next_open);
    accept        = in_valid && (in_sop || frame_open);
    sop_mid       = in_valid && in_sop && frame_open;
    bin_idx       = in_sop ? '0 : cnt;
    last_acc      = accept && (bin_idx == LAST_BIN);
    swap          = (state == DRAIN) && pub_pend;
    // Bins accepted while draining belong to the next frame, whose work bank
    // is the one that is still on display until the swap.
    tag_bank      = (state == DRAIN) ? disp_sel : ~disp_sel;
    cnt_nxt       = accept ? bin_idx + CNT_W'(1) : cnt;
    state_nxt     = state;
    next_open_nxt = next_open;
    case (state)
      IDLE:  if (accept) state_nxt = ACCUM;
      ACCUM: if (last_acc) state_nxt = DRAIN;
      DRAIN: begin
        if (accept) next_open_nxt = 1'b1;
        if (swap) begin
          state_nxt     = (next_open || accept) ? ACCUM : IDLE;
          next_open_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      next_open  <= 1'b0;
      disp_sel   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      next_open  <= next_open_nxt;
      frame_done <= swap;
      sync_err   <= sop_mid;
      if (swap) disp_sel <= ~disp_sel;
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------- magnitude pipeline
  logic [DATA_WIDTH-1:0] mx, mn;
  logic [MAG_W-1:0]      h_full;
  logic [BAR_WIDTH-1:0]  h;
  logic                  wr_en, wr_first;
  logic [BAR_AW-1:0]     wr_bar;

  always_comb begin
    mx       = (s1_a > s1_b) ? s1_a : s1_b;
    mn       = (s1_a > s1_b) ? s1_b : s1_a;
    h_full   = s2_mag >> MAG_SHIFT;
    h        = (h_full > MAG_W'(H_MAX)) ? H_MAX : h_full[BAR_WIDTH-1:0];
    wr_en    = s2_vld && !s2_bin[CNT_W-1];          // upper half is counted but not displayed
    wr_bar   = BAR_AW'(s2_bin >> GRP_W);
    wr_first = ((s2_bin & GRP_MASK) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_bank  <= 1'b0;
      s1_bin   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      s2_bank  <= 1'b0;
      s2_bin   <= '0;
      s2_mag   <= '0;
      pub_pend <= 1'b0;
    end else begin
      s1_vld   <= accept;
      s1_last  <= last_acc;
      s1_bank  <= tag_bank;
      s1_bin   <= bin_idx;
      s1_a     <= abs_val(xk_re);
      s1_b     <= abs_val(xk_im);
      s2_vld   <= s1_vld;
      s2_last  <= s1_vld && s1_last;
      s2_bank  <= s1_bank;
      s2_bin   <= s1_bin;
      s2_mag   <= MAG_W'(mx) + MAG_W'(mn >> 1);
      pub_pend <= s2_vld && s2_last;
    end
  end

  // ---------------------------------------------------------------- bar banks
  always_comb begin
    for (int i = 0; i < NUM_BARS; i++) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
      pub_val[i] = hold_val(bank[~disp_sel][i], bank[disp_sel][i]);
`else
      pub_val[i] = bank[~disp_sel][i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_BARS; i++)
          bank[b][i] <= '0;
    end else begin
      // First bin of a group overwrites, so stale bars from an earlier or aborted frame never leak.
      if (wr_en)
        bank[s2_bank][wr_bar] <= (wr_first || (h > bank[s2_bank][wr_bar])) ? h : bank[s2_bank][wr_bar];
`ifdef SPECTRUM_PEAK_HOLD_EN
      // The finished work bank absorbs the decayed peaks; new-frame writes target the other bank.
      if (swap)
        for (int i = 0; i < NUM_BARS; i++)
          bank[~disp_sel][i] <= pub_val[i];
`endif
    end
  end

  // A read issued in the swap cycle already returns the table being published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= swap ? pub_val[rd_addr] : bank[disp_sel][rd_addr];
  end

endmodule

// File: tb/tb_fft_spectrum_bars.sv
// Purpose : self-checking bench for fft_spectrum_bars against a frame-level reference model.
// Latency : checks publish at T+4 after the last bin and 1-cycle read latency.
// Backpr. : DUT has none; stimulus streams bins with optional random idle gaps.
module tb_fft_spectrum_bars;

  localparam int N  = 1024;
  localparam int NB = 32;
  localparam int GS = (N / 2) / NB;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sop = 1'b0;
  logic signed [15:0] xk_re = '0;
  logic signed [15:0] xk_im = '0;
  logic [4:0]         rd_addr = '0;
  logic [7:0]         rd_data;
  logic               frame_done, busy, sync_err;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int fr_re [N];
  int fr_im [N];
  int disp_m [NB];

  always #5 clk = ~clk;

  fft_spectrum_bars dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .xk_re      (xk_re),
    .xk_im      (xk_im),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .busy       (busy),
    .sync_err   (sync_err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (sync_err)   se_cnt <= se_cnt + 1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bar height from the magnitude rules, in plain integer arithmetic.
  function automatic int h_of(int re, int im);
    int a, b, mx, mn, hh;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    hh = (mx + mn / 2) / 128;
    return (hh > 255) ? 255 : hh;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic fill_rand();
    int sh;
    logic signed [15:0] r;
    sh = $urandom_range(2, 8);
    for (int i = 0; i < N; i++) begin
      r = 16'($urandom);
      fr_re[i] = int'(r) >>> sh;
      r = 16'($urandom);
      fr_im[i] = int'(r) >>> sh;
    end
  endtask

  // Streams bins 0..nbins-1 of fr_re/fr_im; optionally checks the display table stays stable.
  task automatic send_frame(input int nbins, input bit gaps, input bit rdchk);
    for (int i = 0; i < nbins; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        in_valid = 1'b0;
        in_sop   = 1'($urandom_range(0, 1));
        tick();
        if (rdchk && i >= 8) chk("rd_hold", int'(rd_data), disp_m[rd_addr]);
        rd_addr = 5'($urandom);
      end
      in_valid = 1'b1;
      in_sop   = (i == 0);
      xk_re    = 16'(fr_re[i]);
      xk_im    = 16'(fr_im[i]);
      tick();
      if (rdchk && i >= 8) chk("rd_hold", int'(rd_data), disp_m[rd_addr]);
      rd_addr = 5'($urandom);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic publish_model();
    int nb [NB];
    for (int b = 0; b < NB; b++) nb[b] = 0;
    for (int i = 0; i < N / 2; i++) begin
      int hh;
      hh = h_of(fr_re[i], fr_im[i]);
      if (hh > nb[i / GS]) nb[i / GS] = hh;
    end
    for (int b = 0; b < NB; b++) begin
`ifdef SPECTRUM_PEAK_HOLD_EN
      int d;
      d = (disp_m[b] > 0) ? disp_m[b] - 1 : 0;
      disp_m[b] = (nb[b] > d) ? nb[b] : d;
`else
      disp_m[b] = nb[b];
`endif
    end
  endtask

  // Called in cycle T+1 (T = cycle of the last bin); frame_done must appear at T+4.
  task automatic wait_publish();
    int k;
    k = 1;
    chk("busy_run", int'(busy), 1);
    while (!frame_done && k < 12) begin
      tick();
      k++;
    end
    chk("fd_latency", k, 4);
    chk("busy_end", int'(busy), 0);
    tick();
    chk("fd_pulse", int'(frame_done), 0);
  endtask

  task automatic check_all();
    for (int a = 0; a < NB; a++) begin
      rd_addr = 5'(a);
      tick();
      chk($sformatf("bar%0d", a), int'(rd_data), disp_m[a]);
    end
  endtask

  initial begin
    int fd0, se0;
    for (int b = 0; b < NB; b++) disp_m[b] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    check_all();

    // Single tone in bin 16 -> bar 1 = 128
    fill_zero();
    fr_re[16] = 16384;
    send_frame(N, 1'b0, 1'b1);
    publish_model();
    wait_publish();
    check_all();

    // Saturating bin 0, full scale in the upper half (ignored), with idle gaps
    fill_zero();
    fr_re[0]   = -32768;
    fr_im[0]   = -32768;
    fr_re[600] = 32767;
    fr_im[600] = -32768;
    send_frame(N, 1'b1, 1'b1);
    publish_model();
    wait_publish();
    check_all();

    // Random frames
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      send_frame(N, f[0], 1'b1);
      publish_model();
      wait_publish();
      check_all();
    end

    // Peak-hold behaviour on bar 3: 100 then (99 or 0)
    fill_zero();
    fr_re[50] = 12800;
    send_frame(N, 1'b0, 1'b1);
    publish_model();
    wait_publish();
    check_all();
    fill_zero();
    send_frame(N, 1'b0, 1'b1);
    publish_model();
    wait_publish();
    check_all();

    // in_sop at bin 300: partial frame discarded, display untouched
    se0 = se_cnt;
    fd0 = fd_cnt;
    fill_rand();
    send_frame(300, 1'b0, 1'b1);
    fill_rand();
    send_frame(N, 1'b0, 1'b1);
    chk("sync_err_cnt", se_cnt - se0, 1);
    chk("fd_early", fd_cnt - fd0, 0);
    publish_model();
    wait_publish();
    check_all();

    // Back-to-back frames: next in_sop arrives while draining
    fd0 = fd_cnt;
    se0 = se_cnt;
    fill_rand();
    send_frame(N, 1'b0, 1'b1);
    publish_model();
    fill_rand();
    send_frame(N, 1'b0, 1'b1);
    publish_model();
    wait_publish();
    chk("fd_b2b", fd_cnt - fd0, 2);
    chk("se_b2b", se_cnt - se0, 0);
    check_all();

    // Reset mid-frame: everything cleared, no publish
    fd0 = fd_cnt;
    fill_rand();
    send_frame(500, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fd", int'(frame_done), 0);
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < NB; b++) disp_m[b] = 0;
    repeat (6) tick();
    chk("mid_rst_no_fd", fd_cnt - fd0, 0);
    chk("mid_rst_idle", int'(busy), 0);
    check_all();

    // Recovery after reset
    fill_rand();
    send_frame(N, 1'b1, 1'b1);
    publish_model();
    wait_publish();
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
